// File: rtl/pushbutton_event_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pushbutton_event_ctrl
//  Purpose  : Avalon-MM pushbutton controller with per-bit synchroniser,
//             debounce, sticky W1C edge capture and a maskable level irq.
//             Optional macro PB_RELEASE_CAPTURE_EN also captures releases.
//  Revision : 1.0 - initial release
// ============================================================================
module pushbutton_event_ctrl #(
   parameter int WIDTH           = 4,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int CNT_W           = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] in_port,
   output logic             irq
);

   localparam logic [CNT_W-1:0] c_CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [1:0]       c_ADDR_DATA = 2'd0;
   localparam logic [1:0]       c_ADDR_RSVD = 2'd1;
   localparam logic [1:0]       c_ADDR_MASK = 2'd2;
   localparam logic [1:0]       c_ADDR_EDGE = 2'd3;

   logic [WIDTH-1:0] r_sync1;
   logic [WIDTH-1:0] r_sync2;
   logic [WIDTH-1:0] r_stable;
   logic [CNT_W-1:0] r_cnt [WIDTH];
   logic [WIDTH-1:0] r_irq_mask;
   logic [WIDTH-1:0] r_edge_cap;

   logic [WIDTH-1:0] w_stable_nxt;
   logic [CNT_W-1:0] w_cnt_nxt [WIDTH];
   logic [WIDTH-1:0] w_fall;
   logic [WIDTH-1:0] w_set;
   logic [WIDTH-1:0] w_clr;
   logic             w_wr;
   logic             w_rd;
   logic [31:0]      w_rdata;
   logic             w_unused;

   assign w_wr     = chipselect & ~write_n;
   assign w_rd     = chipselect & write_n;
   assign w_unused = &{1'b0, writedata};

   // Any disagreement between sync and stable counts up; agreement clears.
   always_comb begin
      for (int i = 0; i < WIDTH; i++) begin
         w_stable_nxt[i] = r_stable[i];
         w_cnt_nxt[i]    = '0;
         if (r_sync2[i] != r_stable[i]) begin
            if (r_cnt[i] == c_CNT_LAST)
               w_stable_nxt[i] = r_sync2[i];
            else
               w_cnt_nxt[i] = r_cnt[i] + 1'b1;
         end
      end
   end

   assign w_fall = r_stable & ~w_stable_nxt;

`ifdef PB_RELEASE_CAPTURE_EN
   logic [WIDTH-1:0] w_rise;
   assign w_rise = ~r_stable & w_stable_nxt;
   assign w_set  = w_fall | w_rise;
`else
   assign w_set  = w_fall;
`endif

   assign w_clr = (w_wr && address == c_ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;

   always_comb begin
      w_rdata = '0;
      case (address)
         c_ADDR_DATA: w_rdata[WIDTH-1:0] = ~r_stable;
         c_ADDR_RSVD: w_rdata = '0;
         c_ADDR_MASK: w_rdata[WIDTH-1:0] = r_irq_mask;
         c_ADDR_EDGE: w_rdata[WIDTH-1:0] = r_edge_cap;
         default:     w_rdata = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_sync1    <= '1;
         r_sync2    <= '1;
         r_stable   <= '1;
         for (int i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
         r_irq_mask <= '0;
         r_edge_cap <= '0;
         readdata   <= '0;
         irq        <= 1'b0;
      end else begin
         r_sync1  <= in_port;
         r_sync2  <= r_sync1;
         r_stable <= w_stable_nxt;
         for (int i = 0; i < WIDTH; i++) r_cnt[i] <= w_cnt_nxt[i];
         if (w_wr && address == c_ADDR_MASK)
            r_irq_mask <= writedata[WIDTH-1:0];
         // Set term is OR'd last so a same-cycle event beats the clear.
         r_edge_cap <= (r_edge_cap & ~w_clr) | w_set;
         if (w_rd)
            readdata <= w_rdata;
         irq <= |(r_edge_cap & r_irq_mask);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pushbutton_event_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pushbutton_event_ctrl
//  Purpose  : Self-checking bench for pushbutton_event_ctrl (WIDTH=4,
//             DEBOUNCE_CYCLES=4); read expectations flow through a queue.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pushbutton_event_ctrl;

   localparam int WIDTH = 4;

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic [1:0]       address = '0;
   logic             chipselect = 1'b0;
   logic             write_n = 1'b1;
   logic [31:0]      writedata = '0;
   logic [31:0]      readdata;
   logic [WIDTH-1:0] in_port = '1;
   logic             irq;

   int checks = 0;
   int errors = 0;

   logic [31:0] sb_exp  [$];
   string       sb_name [$];

   typedef struct packed {
      logic        wr;
      logic [1:0]  addr;
      logic [31:0] data;
      logic [31:0] exp_rd;
      logic        exp_irq;
   } vec_t;

   vec_t vecs [12];

   pushbutton_event_ctrl #(
      .WIDTH          (WIDTH),
      .DEBOUNCE_CYCLES(4),
      .CNT_W          (3)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .address   (address),
      .chipselect(chipselect),
      .write_n   (write_n),
      .writedata (writedata),
      .readdata  (readdata),
      .in_port   (in_port),
      .irq       (irq)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic sb_pop();
      if (sb_exp.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard: got empty queue expected pending read");
      end else begin
         check(sb_name.pop_front(), readdata, sb_exp.pop_front());
      end
   endtask

   task automatic do_read(input logic [1:0] a, input logic [31:0] exp, input string name);
      chipselect = 1'b1;
      write_n    = 1'b1;
      address    = a;
      sb_exp.push_back(exp);
      sb_name.push_back(name);
      tick();
      chipselect = 1'b0;
      sb_pop();
   endtask

   task automatic do_write(input logic [1:0] a, input logic [31:0] d);
      chipselect = 1'b1;
      write_n    = 1'b0;
      address    = a;
      writedata  = d;
      tick();
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   initial begin
      vecs[0]  = '{1'b0, 2'd0, 32'h0,         32'h0, 1'b0};
      vecs[1]  = '{1'b0, 2'd1, 32'h0,         32'h0, 1'b0};
      vecs[2]  = '{1'b0, 2'd2, 32'h0,         32'h0, 1'b0};
      vecs[3]  = '{1'b0, 2'd3, 32'h0,         32'h0, 1'b0};
      vecs[4]  = '{1'b1, 2'd2, 32'hFFFF_FFFF, 32'h0, 1'b0};
      vecs[5]  = '{1'b0, 2'd2, 32'h0,         32'hF, 1'b0};
      vecs[6]  = '{1'b1, 2'd1, 32'hFFFF_FFFF, 32'h0, 1'b0};
      vecs[7]  = '{1'b0, 2'd1, 32'h0,         32'h0, 1'b0};
      vecs[8]  = '{1'b1, 2'd0, 32'hFFFF_FFFF, 32'h0, 1'b0};
      vecs[9]  = '{1'b0, 2'd0, 32'h0,         32'h0, 1'b0};
      vecs[10] = '{1'b1, 2'd2, 32'h0,         32'h0, 1'b0};
      vecs[11] = '{1'b0, 2'd2, 32'h0,         32'h0, 1'b0};

      repeat (3) tick();
      reset_n = 1'b1;
      check("reset_irq", {31'b0, irq}, 32'h0);

      // Register access table
      for (int i = 0; i < 12; i++) begin
         if (vecs[i].wr)
            do_write(vecs[i].addr, vecs[i].data);
         else
            do_read(vecs[i].addr, vecs[i].exp_rd, $sformatf("vec%0d_read", i));
         check($sformatf("vec%0d_irq", i), {31'b0, irq}, {31'b0, vecs[i].exp_irq});
      end

      // Press bit0: stable changes on the 6th edge after the pin change
      in_port[0] = 1'b0;
      repeat (5) tick();
      do_read(2'd0, 32'h0, "data_before_accept");
      do_read(2'd0, 32'h1, "data_after_accept");
      do_read(2'd3, 32'h1, "edge_cap_bit0");
      check("irq_masked_off", {31'b0, irq}, 32'h0);

      // Bit1 bounces with 2-cycle pulses, then settles released
      for (int k = 0; k < 2; k++) begin
         in_port[1] = 1'b0;
         repeat (2) tick();
         in_port[1] = 1'b1;
         repeat (2) tick();
      end
      repeat (8) tick();
      do_read(2'd0, 32'h1, "bounce_data");
      do_read(2'd3, 32'h1, "bounce_edge_cap");

      // Mask enable raises irq one cycle later; W1C drops it one cycle later
      do_write(2'd2, 32'h1);
      check("irq_mask_same_cycle", {31'b0, irq}, 32'h0);
      tick();
      check("irq_after_mask", {31'b0, irq}, 32'h1);
      do_write(2'd3, 32'h1);
      check("irq_clear_same_cycle", {31'b0, irq}, 32'h1);
      tick();
      check("irq_after_clear", {31'b0, irq}, 32'h0);
      do_read(2'd3, 32'h0, "edge_cap_cleared");

      // W1C on bit2 coincides with its debounced fall: set wins
      in_port[2] = 1'b0;
      repeat (5) tick();
      do_write(2'd3, 32'h4);
      do_read(2'd3, 32'h4, "set_wins_bit2");
      do_read(2'd0, 32'h5, "data_bits02");
      check("irq_bit2_unmasked", {31'b0, irq}, 32'h0);
      do_write(2'd3, 32'h4);
      do_read(2'd3, 32'h0, "edge_cap_bit2_cleared");

      // Release bit0
      in_port[0] = 1'b1;
      repeat (8) tick();
`ifdef PB_RELEASE_CAPTURE_EN
      do_read(2'd3, 32'h1, "release_capture");
      check("release_irq", {31'b0, irq}, 32'h1);
`else
      do_read(2'd3, 32'h0, "release_no_capture");
      check("release_irq", {31'b0, irq}, 32'h0);
`endif
      do_read(2'd0, 32'h4, "data_after_release");

      // Reset mid-debounce on bit3; bits 2 and 3 held pressed through reset
      in_port[3] = 1'b0;
      repeat (3) tick();
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      do_read(2'd3, 32'h0, "post_reset_edge_cap");
      check("post_reset_irq", {31'b0, irq}, 32'h0);
      do_read(2'd0, 32'h0, "post_reset_data");
      repeat (3) tick();
      do_read(2'd0, 32'h0, "held_data_edge6");
      do_read(2'd0, 32'hC, "held_data_accepted");
      do_read(2'd3, 32'hC, "held_edge_cap");
      do_write(2'd2, 32'hF);
      tick();
      check("held_irq", {31'b0, irq}, 32'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
